// File: rtl/y_enhance_apply.sv
// Luma stretch: Y' = sat255(((Y - min) * rate) >> RATE_FRAC) on a 24-bit Avalon-ST stream.
// Coefficients are captured on each accepted sop beat and held for the rest of the frame.
module y_enhance_apply #(
  parameter int RATE_FRAC = 8,
  parameter int PIPE_LAT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] video_in_data,
  input  logic        video_in_valid,
  input  logic        video_in_sop,
  input  logic        video_in_eop,
  output logic        video_in_ready,
  output logic [23:0] video_out_data,
  output logic        video_out_valid,
  output logic        video_out_sop,
  output logic        video_out_eop,
  input  logic        video_out_ready,
  input  logic [15:0] rate,
  input  logic [7:0]  min_in_value,
  input  logic        bypass,
  input  logic        diff2small,
  output logic        frame_done
);

  logic                adv;
  logic                take;
  logic [15:0]         rate_l;
  logic [7:0]          min_l;
  logic                byp_l;
  logic [15:0]         eff_rate;
  logic [7:0]          eff_min;
  logic                eff_byp;
  logic [7:0]          y_in;
  logic [PIPE_LAT-1:0] vld_sr;
  logic [PIPE_LAT-1:0] sop_sr;
  logic [PIPE_LAT-1:0] eop_sr;

  logic [7:0]  s1_d;
  logic [7:0]  s1_y;
  logic [15:0] s1_cbcr;
  logic        s1_byp;
  logic [15:0] s1_rate;

  logic [23:0] s2_p;
  logic [7:0]  s2_y;
  logic [15:0] s2_cbcr;
  logic        s2_byp;

  logic [23:0] q;
  logic [7:0]  y_new;

  assign adv            = ~video_out_valid | video_out_ready;
  assign video_in_ready = adv;
  assign take           = adv & video_in_valid;
  assign y_in           = video_in_data[23:16];

  // The sop beat itself must already use the incoming coefficients.
  assign eff_rate = video_in_sop ? rate : rate_l;
  assign eff_min  = video_in_sop ? min_in_value : min_l;
  assign eff_byp  = video_in_sop ? (bypass | diff2small) : byp_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_l <= 16'h100;
      min_l  <= 8'd0;
      byp_l  <= 1'b1;
    end else if (take && video_in_sop) begin
      rate_l <= rate;
      min_l  <= min_in_value;
      byp_l  <= bypass | diff2small;
    end
  end

  // Control shift registers; bubbles travel as valid=0 and are never collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      sop_sr <= '0;
      eop_sr <= '0;
    end else if (adv) begin
      vld_sr <= {vld_sr[PIPE_LAT-2:0], video_in_valid};
      sop_sr <= {sop_sr[PIPE_LAT-2:0], video_in_valid & video_in_sop};
      eop_sr <= {eop_sr[PIPE_LAT-2:0], video_in_valid & video_in_eop};
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_d    <= (y_in >= eff_min) ? (y_in - eff_min) : 8'd0;
      s1_y    <= y_in;
      s1_cbcr <= video_in_data[15:0];
      s1_byp  <= eff_byp;
      s1_rate <= eff_rate;
      s2_p    <= {16'd0, s1_d} * {8'd0, s1_rate};
      s2_y    <= s1_y;
      s2_cbcr <= s1_cbcr;
      s2_byp  <= s1_byp;
    end
  end

  assign q     = s2_p >> RATE_FRAC;
  assign y_new = s2_byp ? s2_y : ((q > 24'd255) ? 8'hff : q[7:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      video_out_data <= 24'd0;
    end else if (adv) begin
      video_out_data <= {y_new, s2_cbcr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= video_out_valid & video_out_ready & video_out_eop;
    end
  end

  assign video_out_valid = vld_sr[PIPE_LAT-1];
  assign video_out_sop   = sop_sr[PIPE_LAT-1];
  assign video_out_eop   = eop_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_y_enhance_apply.sv
// Directed bench for y_enhance_apply: gain/offset, saturation, backpressure,
// coefficient latching, bypass and mid-frame reset.
module tb_y_enhance_apply;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] video_in_data = '0;
  logic        video_in_valid = 1'b0;
  logic        video_in_sop = 1'b0;
  logic        video_in_eop = 1'b0;
  logic        video_in_ready;
  logic [23:0] video_out_data;
  logic        video_out_valid;
  logic        video_out_sop;
  logic        video_out_eop;
  logic        video_out_ready = 1'b1;
  logic [15:0] rate = 16'h100;
  logic [7:0]  min_in_value = '0;
  logic        bypass = 1'b0;
  logic        diff2small = 1'b0;
  logic        frame_done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_in_cyc = 0;
  int fd_count = 0;

  logic [23:0] od_q[$];
  bit          os_q[$];
  bit          oe_q[$];
  int          oc_q[$];

  y_enhance_apply #(.RATE_FRAC(8), .PIPE_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .video_in_data(video_in_data), .video_in_valid(video_in_valid),
    .video_in_sop(video_in_sop), .video_in_eop(video_in_eop),
    .video_in_ready(video_in_ready),
    .video_out_data(video_out_data), .video_out_valid(video_out_valid),
    .video_out_sop(video_out_sop), .video_out_eop(video_out_eop),
    .video_out_ready(video_out_ready),
    .rate(rate), .min_in_value(min_in_value), .bypass(bypass),
    .diff2small(diff2small), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && video_out_valid && video_out_ready) begin
      od_q.push_back(video_out_data);
      os_q.push_back(video_out_sop);
      oe_q.push_back(video_out_eop);
      oc_q.push_back(cyc);
    end
    if (!rst && frame_done) fd_count++;
  end

  function automatic logic [7:0] exp_y(input logic [7:0] y, input logic [7:0] mn,
                                       input logic [15:0] r, input bit byp);
    int d, p;
    if (byp) return y;
    d = (y >= mn) ? (int'(y) - int'(mn)) : 0;
    p = (d * int'(r)) / 256;
    return (p > 255) ? 8'hff : 8'(p);
  endfunction

  task automatic clear_capture();
    od_q.delete(); os_q.delete(); oe_q.delete(); oc_q.delete();
    fd_count = 0;
  endtask

  task automatic send_beat(input logic [7:0] y, input logic [15:0] c, input bit s, input bit e);
    bit accepted = 0;
    video_in_data  = {y, c};
    video_in_sop   = s;
    video_in_eop   = e;
    video_in_valid = 1'b1;
    last_in_cyc    = cyc;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      accepted = video_in_ready;
      @(posedge clk); #1;
    end
    if (!accepted) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL send_beat timeout: beat y=%0d never accepted, need ready=1", y);
    end
  endtask

  task automatic idle();
    video_in_valid = 1'b0;
    video_in_sop   = 1'b0;
    video_in_eop   = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (od_q.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (od_q.size() < n) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL wait_out timeout: got %0d beats, need %0d", od_q.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (video_out_valid !== 1'b0 || video_out_sop !== 1'b0 || video_out_eop !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: valid/sop/eop=%b%b%b, need 000", video_out_valid, video_out_sop, video_out_eop);
    end
    n_checks++;
    if (video_out_data !== 24'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h, need 000000", video_out_data);
    end
    n_checks++;
    if (frame_done !== 1'b0 || video_in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_fd_ready: frame_done=%b ready=%b, need 0 1", frame_done, video_in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_identity();
    int first_in = 0;
    @(posedge clk); #1;
    clear_capture();
    rate = 16'h100; min_in_value = 8'd0; bypass = 1'b0; diff2small = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_beat(8'(i), {8'(i * 3), 8'(8'h80 + i)}, i == 0, i == 7);
      if (i == 0) first_in = last_in_cyc;
    end
    idle();
    wait_out(8);
    for (int i = 0; i < 8 && i < od_q.size(); i++) begin
      n_checks++;
      if (od_q[i] !== {8'(i), 8'(i * 3), 8'(8'h80 + i)} || os_q[i] !== (i == 0) || oe_q[i] !== (i == 7)) begin
        n_fail++;
        $display("[TB] FAIL identity[%0d]: got %h sop=%b eop=%b, need %h sop=%b eop=%b", i,
                 od_q[i], os_q[i], oe_q[i], {8'(i), 8'(i * 3), 8'(8'h80 + i)}, i == 0, i == 7);
      end
    end
    n_checks++;
    if (od_q.size() == 0 || oc_q[0] - first_in != 3) begin
      n_fail++;
      $display("[TB] FAIL latency: got %0d cycles, need 3", (od_q.size() == 0) ? -1 : oc_q[0] - first_in);
    end
    n_checks++;
    if (fd_count != 1) begin
      n_fail++;
      $display("[TB] FAIL identity_frame_done: got %0d pulses, need 1", fd_count);
    end
  endtask

  task automatic test_gain_saturate();
    logic [7:0] yv[5] = '{8'd100, 8'd10, 8'd200, 8'd16, 8'd143};
    logic [7:0] ev[5] = '{8'd168, 8'd0, 8'd255, 8'd0, 8'd254};
    @(posedge clk); #1;
    clear_capture();
    rate = 16'h200; min_in_value = 8'd16; bypass = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(yv[i], 16'h1234, i == 0, i == 4);
    idle();
    wait_out(5);
    for (int i = 0; i < 5 && i < od_q.size(); i++) begin
      n_checks++;
      if (od_q[i] !== {ev[i], 16'h1234}) begin
        n_fail++;
        $display("[TB] FAIL gain[%0d]: got %h, need %h", i, od_q[i], {ev[i], 16'h1234});
      end
    end
  endtask

  task automatic test_single_pixel();
    @(posedge clk); #1;
    clear_capture();
    rate = 16'h0000; min_in_value = 8'd0;
    send_beat(8'd200, 16'hAA55, 1'b1, 1'b1);
    rate = 16'h100; min_in_value = 8'd50;
    send_beat(8'd200, 16'h55AA, 1'b1, 1'b1);
    idle();
    wait_out(2);
    n_checks++;
    if (od_q.size() < 2 || od_q[0] !== 24'h00AA55 || os_q[0] !== 1'b1 || oe_q[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rate_zero: got %h, need 00aa55 sop=1 eop=1", (od_q.size() > 0) ? od_q[0] : 24'hx);
    end
    n_checks++;
    if (od_q.size() < 2 || od_q[1] !== 24'h9655AA) begin
      n_fail++;
      $display("[TB] FAIL one_pixel: got %h, need 9655aa", (od_q.size() > 1) ? od_q[1] : 24'hx);
    end
    n_checks++;
    if (fd_count != 2) begin
      n_fail++;
      $display("[TB] FAIL one_pixel_frame_done: got %0d, need 2", fd_count);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] held = '0;
    @(posedge clk); #1;
    clear_capture();
    rate = 16'h180; min_in_value = 8'd8; bypass = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_beat(8'(i * 27), {8'(i), 8'(255 - i)}, i == 0, i == 9);
        idle();
      end
      begin
        repeat (5) @(posedge clk); #1;
        video_out_ready = 1'b0;
        held = video_out_data;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_checks++;
          if (video_in_ready !== 1'b0 || video_out_valid !== 1'b1 || video_out_data !== held) begin
            n_fail++;
            $display("[TB] FAIL stall[%0d]: in_ready=%b valid=%b data=%h, need 0 1 %h", k,
                     video_in_ready, video_out_valid, video_out_data, held);
          end
          @(posedge clk); #1;
        end
        video_out_ready = 1'b1;
      end
    join
    wait_out(10);
    n_checks++;
    if (od_q.size() != 10) begin
      n_fail++;
      $display("[TB] FAIL stall_count: got %0d beats, need 10", od_q.size());
    end
    for (int i = 0; i < 10 && i < od_q.size(); i++) begin
      n_checks++;
      if (od_q[i] !== {exp_y(8'(i * 27), 8'd8, 16'h180, 0), 8'(i), 8'(255 - i)}) begin
        n_fail++;
        $display("[TB] FAIL stall_data[%0d]: got %h, need %h", i, od_q[i],
                 {exp_y(8'(i * 27), 8'd8, 16'h180, 0), 8'(i), 8'(255 - i)});
      end
    end
  endtask

  task automatic test_coef_latch();
    logic [7:0] ya[4] = '{8'd100, 8'd100, 8'd200, 8'd16};
    logic [7:0] ea[4] = '{8'd168, 8'd168, 8'd255, 8'd0};
    logic [7:0] yb[3] = '{8'd100, 8'd50, 8'd143};
    logic [7:0] eb[3] = '{8'd252, 8'd102, 8'd255};
    @(posedge clk); #1;
    clear_capture();
    rate = 16'h200; min_in_value = 8'd16;
    for (int i = 0; i < 4; i++) begin
      send_beat(ya[i], 16'h0000, i == 0, i == 3);
      if (i == 1) rate = 16'h300;
    end
    for (int i = 0; i < 3; i++) send_beat(yb[i], 16'h0000, i == 0, i == 2);
    idle();
    wait_out(7);
    for (int i = 0; i < 7 && i < od_q.size(); i++) begin
      n_checks++;
      if (od_q[i][23:16] !== ((i < 4) ? ea[i] : eb[i - 4])) begin
        n_fail++;
        $display("[TB] FAIL latch[%0d]: got %0d, need %0d", i, od_q[i][23:16], (i < 4) ? ea[i] : eb[i - 4]);
      end
    end
  endtask

  task automatic test_diff2small();
    logic [7:0] yv[3] = '{8'd100, 8'd10, 8'd200};
    @(posedge clk); #1;
    clear_capture();
    rate = 16'h200; min_in_value = 8'd16; diff2small = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 3; i++) send_beat(yv[i], 16'h7F7F, i == 0, i == 2);
    idle();
    diff2small = 1'b0;
    wait_out(6);
    for (int i = 0; i < 6 && i < od_q.size(); i++) begin
      n_checks++;
      if (od_q[i] !== {yv[i % 3], 16'h7F7F}) begin
        n_fail++;
        $display("[TB] FAIL d2s[%0d]: got %h, need %h", i, od_q[i], {yv[i % 3], 16'h7F7F});
      end
    end
    n_checks++;
    if (fd_count != 2) begin
      n_fail++;
      $display("[TB] FAIL d2s_frame_done: got %0d, need 2", fd_count);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] ev[3] = '{8'd100, 8'd168, 8'd254};
    @(posedge clk); #1;
    clear_capture();
    rate = 16'h200; min_in_value = 8'd16; bypass = 1'b0;
    send_beat(8'd100, 16'h0101, 1'b1, 1'b0);
    send_beat(8'd50, 16'h0202, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (video_out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flush_valid: got %b, need 0", video_out_valid);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (od_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_stale: got %0d beats, need 0", od_q.size());
    end
    @(posedge clk); #1;
    send_beat(8'd100, 16'h0303, 1'b0, 1'b0);
    send_beat(8'd100, 16'h0404, 1'b1, 1'b0);
    send_beat(8'd143, 16'h0505, 1'b0, 1'b1);
    idle();
    wait_out(3);
    for (int i = 0; i < 3 && i < od_q.size(); i++) begin
      n_checks++;
      if (od_q[i][23:16] !== ev[i] || os_q[i] !== (i == 1) || oe_q[i] !== (i == 2)) begin
        n_fail++;
        $display("[TB] FAIL post_reset[%0d]: got y=%0d sop=%b eop=%b, need y=%0d sop=%b eop=%b", i,
                 od_q[i][23:16], os_q[i], oe_q[i], ev[i], i == 1, i == 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_gain_saturate();
    test_single_pixel();
    test_backpressure();
    test_coef_latch();
    test_diff2small();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
